// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle fetch/decode/execute/mem/writeback control FSM.
// Define CTRL_TIMEOUT_EN to halt with a sticky ERR on a stalled memory wait.
module ctrl_mc #(
  parameter int OP_W   = 4,
  parameter int COND_W = 4,
  parameter int TO_CYC = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OP_W-1:0]   OPCODE,
  input  logic [COND_W-1:0] MM,
  input  logic [COND_W-1:0] STAT,
  input  logic              MEM_ACK,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic              IR_LOAD,
  output logic              PC_WRITE,
  output logic              PC_SEL,
  output logic              BR_SEL,
  output logic              PC_RST,
  output logic              RF_WE,
  output logic [1:0]        ALU_OP,
  output logic              WB_SEL,
  output logic              RD_SEL,
  output logic              HALTED,
  output logic              ERR,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

  localparam logic [COND_W-1:0] MM_IMM  = COND_W'(8);
  localparam logic [COND_W-1:0] MM_ZERO = '0;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [COND_W-1:0] mm_q, mm_d;
  logic              br_hit;
  logic              taken;
  logic              to_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_START0;
      op_q    <= '0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mm_q    <= mm_d;
    end
  end

  // bra/brr branch when every masked flag is set; bne is the inverse
  assign br_hit = ((mm_q & STAT) == mm_q);
  assign taken  = ((op_q == OP_BRA) || (op_q == OP_BRR)) ? br_hit
                : ((op_q == OP_BNE) && !br_hit);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mm_d     = mm_q;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    IR_LOAD  = 1'b0;
    PC_WRITE = 1'b0;
    PC_SEL   = 1'b0;
    BR_SEL   = 1'b0;
    PC_RST   = 1'b0;
    RF_WE    = 1'b0;
    ALU_OP   = 2'b00;
    WB_SEL   = 1'b0;
    RD_SEL   = 1'b0;
    HALTED   = 1'b0;
    unique case (state_q)
      S_START0: begin
        PC_RST  = 1'b1;
        state_d = S_START1;
      end
      S_START1: state_d = S_FETCH;
      S_FETCH: begin
        MEM_REQ = 1'b1;
        if (MEM_ACK) begin
          IR_LOAD  = 1'b1;
          PC_WRITE = 1'b1;
          state_d  = S_DECODE;
        end else if (to_hit) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        op_d    = OPCODE;
        mm_d    = MM;
        BR_SEL  = (OPCODE != OP_BRR);
        state_d = (OPCODE == OP_HLT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        ALU_OP = (mm_q == MM_IMM) ? 2'b01 : 2'b00;
        BR_SEL = (op_q != OP_BRR);
        if (taken) begin
          PC_SEL   = 1'b1;
          PC_WRITE = 1'b1;
        end
        if ((op_q == OP_LOD) || (op_q == OP_STR))
          state_d = S_MEM;
        else if (op_q == OP_ALU)
          state_d = S_WRITEBACK;
        else
          state_d = S_FETCH;
      end
      S_MEM: begin
        MEM_REQ = 1'b1;
        MEM_WE  = (op_q == OP_STR);
        if (MEM_ACK)
          state_d = (op_q == OP_LOD) ? S_WRITEBACK : S_FETCH;
        else if (to_hit)
          state_d = S_HALT;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        if (op_q == OP_LOD) begin
          RF_WE  = 1'b1;
          WB_SEL = 1'b1;
        end else begin
          // only reg-reg (0) and immediate (8) modes write back
          RF_WE  = (mm_q == MM_ZERO) || (mm_q == MM_IMM);
          RD_SEL = (mm_q == MM_ZERO);
        end
      end
      S_HALT: HALTED = 1'b1;
    endcase
  end

  assign STATE = state_q;

`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             err_q, err_d;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MEM_ACK;
  assign to_hit  = waiting && (cnt_q == CNT_MAX);
  assign cnt_d   = (waiting && !to_hit) ? cnt_q + 1'b1 : '0;
  assign err_d   = err_q | to_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign to_hit = 1'b0;
  assign ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: vector table, corner sequences and a randomized cycle-trace
// model for ctrl_mc.
module tb_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode, mm, stat;
  logic       ack;
  logic       mem_req, mem_we, ir_load, pc_write, pc_sel, br_sel, pc_rst;
  logic       rf_we, wb_sel, rd_sel, halted, err;
  logic [1:0] alu_op;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  ctrl_mc #(.OP_W(4), .COND_W(4), .TO_CYC(16)) dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .MM(mm), .STAT(stat),
    .MEM_ACK(ack), .MEM_REQ(mem_req), .MEM_WE(mem_we),
    .IR_LOAD(ir_load), .PC_WRITE(pc_write), .PC_SEL(pc_sel),
    .BR_SEL(br_sel), .PC_RST(pc_rst), .RF_WE(rf_we), .ALU_OP(alu_op),
    .WB_SEL(wb_sel), .RD_SEL(rd_sel), .HALTED(halted), .ERR(err),
    .STATE(state)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] S0 = 3'd0, S1 = 3'd1, SF = 3'd2, SD = 3'd3;
  localparam logic [2:0] SE = 3'd4, SM = 3'd5, SW = 3'd6, SH = 3'd7;

  localparam logic [13:0] REQ = 14'h2000, WE  = 14'h1000;
  localparam logic [13:0] IRL = 14'h0800, PCW = 14'h0400;
  localparam logic [13:0] PCS = 14'h0200, BRS = 14'h0100;
  localparam logic [13:0] PCR = 14'h0080, RFW = 14'h0040;
  localparam logic [13:0] AL1 = 14'h0010, WBS = 14'h0008;
  localparam logic [13:0] RDS = 14'h0004, HLT = 14'h0002;
  localparam logic [13:0] ERB = 14'h0001;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  st;
    logic [16:0] exp;
  } cyc_t;

  typedef struct {
    logic [3:0]  op, mm, st;
    logic [13:0] ex, me, wb;
    int          len;
  } vec_t;

  cyc_t q[$];
  vec_t tbl[13];
  logic [3:0] defs[7];

  function automatic logic [13:0] flg();
    return {mem_req, mem_we, ir_load, pc_write, pc_sel, br_sel, pc_rst,
            rf_we, alu_op, wb_sel, rd_sel, halted, err};
  endfunction

  function automatic logic [16:0] obs();
    return {state, flg()};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s #%0d got=%h want=%h", nm, idx, got, want);
    end
  endtask

  function automatic cyc_t cy(input logic a, input logic [2:0] s,
                              input logic [13:0] f);
    cyc_t c;
    c.rst = 1'b0;
    c.ack = a;
    c.op  = 4'($urandom);
    c.mm  = 4'($urandom);
    c.st  = 4'($urandom);
    c.exp = {s, f};
    return c;
  endfunction

  function automatic cyc_t dec(input logic [3:0] op, input logic [3:0] m);
    cyc_t c;
    c = cy(1'($urandom), SD, (op != 4'd5) ? BRS : 14'd0);
    c.op = op;
    c.mm = m;
    return c;
  endfunction

  function automatic cyc_t exe(input logic [3:0] op, input logic [3:0] m,
                               input logic [3:0] s);
    cyc_t c;
    logic all, tk;
    logic [13:0] f;
    all = ((m & s) == m);
    tk  = (op == 4'd4 || op == 4'd5) ? all : (op == 4'd6) ? !all : 1'b0;
    f   = ((m == 4'd8) ? AL1 : 14'd0) | ((op != 4'd5) ? BRS : 14'd0)
        | (tk ? (PCS | PCW) : 14'd0);
    c = cy(1'($urandom), SE, f);
    c.st = s;
    return c;
  endfunction

  task automatic push_rst(input logic [16:0] cur);
    cyc_t c;
    c = cy(1'($urandom), S0, 14'd0);
    c.rst = 1'b1;
    c.exp = cur;
    q.push_back(c);
    q.push_back(cy(1'($urandom), S0, PCR));
    q.push_back(cy(1'($urandom), S1, 14'd0));
  endtask

  // expected cycle trace of one instruction, starting on FETCH entry
  task automatic instr(input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] s, input int fw, input int mw);
    logic [13:0] mf;
    for (int i = 0; i < fw; i++) q.push_back(cy(1'b0, SF, REQ));
    q.push_back(cy(1'b1, SF, REQ | IRL | PCW));
    q.push_back(dec(op, m));
    if (op == 4'd15) begin
      for (int i = 0; i < 3; i++) q.push_back(cy(1'($urandom), SH, HLT));
      push_rst({SH, HLT});
      return;
    end
    q.push_back(exe(op, m, s));
    if (op == 4'd1 || op == 4'd2) begin
      mf = REQ | ((op == 4'd2) ? WE : 14'd0);
      for (int i = 0; i < mw; i++) q.push_back(cy(1'b0, SM, mf));
      q.push_back(cy(1'b1, SM, mf));
    end
    if (op == 4'd1)
      q.push_back(cy(1'($urandom), SW, RFW | WBS));
    if (op == 4'd8)
      q.push_back(cy(1'($urandom), SW,
        ((m == 4'd0 || m == 4'd8) ? RFW : 14'd0)
        | ((m == 4'd0) ? RDS : 14'd0)));
  endtask

  task automatic run_q();
    cyc_t c;
    int   n;
    n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      rst = c.rst;
      ack = c.ack;
      opcode = c.op;
      mm = c.mm;
      stat = c.st;
      @(negedge clk);
      chk("trace", n, 32'(obs()), 32'(c.exp));
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    logic [13:0] fe, fm, fb;
    logic [3:0] op, m;
    int fw, mw;

    tbl[0]  = '{4'd8, 4'd0, 4'd0, BRS,             14'd0,    RFW | RDS, 4};
    tbl[1]  = '{4'd8, 4'd8, 4'd0, BRS | AL1,       14'd0,    RFW,       4};
    tbl[2]  = '{4'd8, 4'd3, 4'd0, BRS,             14'd0,    14'd0,     4};
    tbl[3]  = '{4'd4, 4'd3, 4'd7, BRS | PCS | PCW, 14'd0,    14'd0,     3};
    tbl[4]  = '{4'd4, 4'd3, 4'd4, BRS,             14'd0,    14'd0,     3};
    tbl[5]  = '{4'd5, 4'd3, 4'd7, PCS | PCW,       14'd0,    14'd0,     3};
    tbl[6]  = '{4'd6, 4'd3, 4'd4, BRS | PCS | PCW, 14'd0,    14'd0,     3};
    tbl[7]  = '{4'd6, 4'd3, 4'd7, BRS,             14'd0,    14'd0,     3};
    tbl[8]  = '{4'd4, 4'd0, 4'd0, BRS | PCS | PCW, 14'd0,    14'd0,     3};
    tbl[9]  = '{4'd1, 4'd0, 4'd5, BRS,             REQ,      RFW | WBS, 5};
    tbl[10] = '{4'd2, 4'd0, 4'd5, BRS,             REQ | WE, 14'd0,     4};
    tbl[11] = '{4'd0, 4'd8, 4'd2, BRS | AL1,       14'd0,    14'd0,     3};
    tbl[12] = '{4'd3, 4'd0, 4'd0, BRS,             14'd0,    14'd0,     3};
    defs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8};

    rst = 1'b1; ack = 1'b1; opcode = 4'd0; mm = 4'd0; stat = 4'd0;
    @(posedge clk);
    #1;
    push_rst({S0, PCR});
    run_q();

    for (int r = 0; r < 13; r++) begin
      opcode = tbl[r].op;
      mm = tbl[r].mm;
      stat = tbl[r].st;
      ack = 1'b1;
      rst = 1'b0;
      n = 0; fe = '0; fm = '0; fb = '0;
      do begin
        @(negedge clk);
        if (state == SE) fe = flg();
        if (state == SM) fm = flg();
        if (state == SW) fb = flg();
        n++;
        @(posedge clk);
        #1;
      end while (state != SF && n < 10);
      chk("vec_len", r, n, tbl[r].len);
      chk("vec_exec", r, 32'(fe), 32'(tbl[r].ex));
      chk("vec_mem", r, 32'(fm), 32'(tbl[r].me));
      chk("vec_wb", r, 32'(fb), 32'(tbl[r].wb));
    end

    instr(4'd1, 4'd0, 4'd0, 0, 3);
    instr(4'd2, 4'd0, 4'd0, 0, 1);
    instr(4'd8, 4'd0, 4'd0, 15, 0);
    instr(4'd15, 4'd0, 4'd0, 0, 0);
    run_q();

    q.push_back(cy(1'b1, SF, REQ | IRL | PCW));
    q.push_back(dec(4'd1, 4'd0));
    q.push_back(exe(4'd1, 4'd0, 4'd0));
    q.push_back(cy(1'b0, SM, REQ));
    q.push_back(cy(1'b0, SM, REQ));
    push_rst({SM, REQ});
    run_q();

`ifdef CTRL_TIMEOUT_EN
    for (int i = 0; i < 16; i++) q.push_back(cy(1'b0, SF, REQ));
    for (int i = 0; i < 3; i++) q.push_back(cy(1'b0, SH, HLT | ERB));
    push_rst({SH, HLT | ERB});
    run_q();
`endif

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 24) == 0)
        op = 4'd15;
      else if ($urandom_range(0, 3) == 0)
        op = 4'($urandom_range(0, 14));
      else
        op = defs[$urandom_range(0, 6)];
      case ($urandom_range(0, 2))
        0: m = 4'd0;
        1: m = 4'd8;
        default: m = 4'($urandom);
      endcase
      fw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2);
      instr(op, m, 4'($urandom), fw, mw);
      run_q();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
